// File: rtl/cpu_pkg.sv
// Shared pipeline constants: instruction field positions,
// register-file widths and the hazard FSM state encoding.
package cpu_pkg;

    localparam int INST_W = 16;
    localparam int REG_W  = 4;
    localparam int RS_LSB = 4;
    localparam int RT_LSB = 0;

    localparam logic [REG_W-1:0] REG_ZERO = 4'd0;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_TIMEOUT
    } hz_state_e;

    function automatic logic [REG_W-1:0] rs_of(input logic [INST_W-1:0] inst);
        return inst[RS_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] rt_of(input logic [INST_W-1:0] inst);
        return inst[RT_LSB +: REG_W];
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination feeds a source
// register of the instruction sitting in ID.
module load_use_detect
    import cpu_pkg::*;
(
    input  logic [INST_W-1:0] id_inst,
    input  logic              id_uses_rt,
    input  logic              idex_memread,
    input  logic [REG_W-1:0]  idex_rd,
    output logic              hazard
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (idex_rd == rs_of(id_inst));
    assign rt_hit = id_uses_rt && (idex_rd == rt_of(id_inst));

    assign hazard = idex_memread && (idex_rd != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and
// data-memory wait freeze with a timeout trap and stall counter.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] id_inst,
    input  logic              id_uses_rt,
    input  logic              idex_memread,
    input  logic [REG_W-1:0]  idex_rd,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_stall,
    output logic              idex_bubble,
    output logic              exmem_stall,
    output logic              memwb_bubble,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    hz_state_e         state_q;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  stall_d;
    logic              lu_hazard;
    logic              mem_wait;

    load_use_detect u_lud (
        .id_inst      (id_inst),
        .id_uses_rt   (id_uses_rt),
        .idex_memread (idex_memread),
        .idex_rd      (idex_rd),
        .hazard       (lu_hazard)
    );

    assign mem_wait = mem_req && !mem_ready;

    // Frozen-pipeline cases win so deferred branch/load-use wait for EX to move.
    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_stall   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_stall  = 1'b0;
        memwb_bubble = 1'b0;
        mem_timeout  = 1'b0;
        if (!rst) begin
            if (state_q == ST_TIMEOUT || mem_wait) begin
                pc_stall     = 1'b1;
                ifid_stall   = 1'b1;
                idex_stall   = 1'b1;
                exmem_stall  = 1'b1;
                memwb_bubble = 1'b1;
                mem_timeout  = (state_q == ST_TIMEOUT);
            end else if (ex_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (lu_hazard) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end
        end
    end

    // wait_q holds the number of wait cycles already spent.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (mem_wait) begin
                        state_q <= ST_MEM_WAIT;
                        wait_q  <= WAIT_W'(1);
                    end else begin
                        wait_q <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_wait) begin
                        state_q <= ST_RUN;
                        wait_q  <= '0;
                    end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
                        state_q <= ST_TIMEOUT;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                ST_TIMEOUT: begin
                    state_q <= ST_TIMEOUT;
                end
                default: begin
                    state_q <= ST_RUN;
                    wait_q  <= '0;
                end
            endcase
        end
    end

    assign stall_d = (pc_stall && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: default instance plus a
// CNT_W=4 instance sharing stimulus to exercise counter saturation.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] id_inst;
    logic        id_uses_rt;
    logic        idex_memread;
    logic [3:0]  idex_rd;
    logic        ex_branch_taken;
    logic        mem_req;
    logic        mem_ready;

    logic        pc_stall, ifid_stall, ifid_flush, idex_stall;
    logic        idex_bubble, exmem_stall, memwb_bubble, mem_timeout;
    logic [15:0] stall_cycles;

    logic        pc_stall4, ifid_stall4, ifid_flush4, idex_stall4;
    logic        idex_bubble4, exmem_stall4, memwb_bubble4, mem_timeout4;
    logic [3:0]  stall_cycles4;

    logic [7:0]  outs;

    int n_chk;
    int n_pass;

    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_LU   = 8'b1100_1000;
    localparam logic [7:0] O_BR   = 8'b0010_1000;
    localparam logic [7:0] O_WAIT = 8'b1101_0110;
    localparam logic [7:0] O_TO   = 8'b1101_0111;

    hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_inst         (id_inst),
        .id_uses_rt      (id_uses_rt),
        .idex_memread    (idex_memread),
        .idex_rd         (idex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_stall      (idex_stall),
        .idex_bubble     (idex_bubble),
        .exmem_stall     (exmem_stall),
        .memwb_bubble    (memwb_bubble),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles)
    );

    hazard_ctrl #(.MAX_WAIT(15), .CNT_W(4)) dut4 (
        .clk             (clk),
        .rst             (rst),
        .id_inst         (id_inst),
        .id_uses_rt      (id_uses_rt),
        .idex_memread    (idex_memread),
        .idex_rd         (idex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_stall        (pc_stall4),
        .ifid_stall      (ifid_stall4),
        .ifid_flush      (ifid_flush4),
        .idex_stall      (idex_stall4),
        .idex_bubble     (idex_bubble4),
        .exmem_stall     (exmem_stall4),
        .memwb_bubble    (memwb_bubble4),
        .mem_timeout     (mem_timeout4),
        .stall_cycles    (stall_cycles4)
    );

    assign outs = {pc_stall, ifid_stall, ifid_flush, idex_stall,
                   idex_bubble, exmem_stall, memwb_bubble, mem_timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_inst         = 16'h0000;
        id_uses_rt      = 1'b0;
        idex_memread    = 1'b0;
        idex_rd         = 4'd0;
        ex_branch_taken = 1'b0;
        mem_req         = 1'b0;
        mem_ready       = 1'b0;
    endtask

    task automatic set_lu(input logic [3:0] rd, input logic [15:0] inst, input logic urt);
        idex_memread = 1'b1;
        idex_rd      = rd;
        id_inst      = inst;
        id_uses_rt   = urt;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        idle();
        rst = 1'b1;
        mem_req = 1'b1;
        ex_branch_taken = 1'b1;
        set_lu(4'd3, 16'h0030, 1'b0);
        #1;
        chk("rst_outs", 32'(outs), 32'(O_NONE));
        chk("rst_outs4", 32'(mem_timeout4 | pc_stall4), 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        idle();
        #1;
        chk("idle_outs", 32'(outs), 32'(O_NONE));
        chk("rst_sc", 32'(stall_cycles), 32'd0);

        set_lu(4'd3, 16'h0030, 1'b0);
        #1;
        chk("lu_rs", 32'(outs), 32'(O_LU));
        cyc();
        idle();
        #1;
        chk("lu_one_cycle", 32'(outs), 32'(O_NONE));
        chk("lu_sc", 32'(stall_cycles), 32'd1);

        set_lu(4'd0, 16'h0000, 1'b1);
        #1;
        chk("r0_no_hz", 32'(outs), 32'(O_NONE));
        set_lu(4'd5, 16'h0005, 1'b0);
        #1;
        chk("rt_unused", 32'(outs), 32'(O_NONE));
        id_uses_rt = 1'b1;
        #1;
        chk("lu_rt", 32'(outs), 32'(O_LU));
        idex_memread = 1'b0;
        #1;
        chk("no_load", 32'(outs), 32'(O_NONE));
        id_uses_rt = 1'b1;
        idex_memread = 1'b1;
        cyc();
        idle();
        #1;
        chk("sc_two", 32'(stall_cycles), 32'd2);

        set_lu(4'd3, 16'h0030, 1'b0);
        ex_branch_taken = 1'b1;
        #1;
        chk("br_over_lu", 32'(outs), 32'(O_BR));
        cyc();
        idle();
        ex_branch_taken = 1'b1;
        #1;
        chk("br_alone", 32'(outs), 32'(O_BR));
        cyc();
        idle();
        #1;
        chk("br_no_sc", 32'(stall_cycles), 32'd2);

        mem_req = 1'b1;
        mem_ready = 1'b0;
        ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("wait_%0d", i), 32'(outs), 32'(O_WAIT));
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        chk("wait_end_br", 32'(outs), 32'(O_BR));
        cyc();
        idle();
        mem_ready = 1'b1;
        #1;
        chk("wait_sc", 32'(stall_cycles), 32'd5);
        chk("ready_no_req", 32'(outs), 32'(O_NONE));
        cyc();

        for (int i = 0; i < 20; i++) begin
            mem_req   = (i < 17);
            mem_ready = (i >= 17);
            #1;
            chk($sformatf("to_cyc%0d", i + 1), 32'(outs), 32'(i < 16 ? O_WAIT : O_TO));
            cyc();
        end
        chk("to_sc", 32'(stall_cycles), 32'd25);
        chk("sat_sc4", 32'(stall_cycles4), 32'd15);
        rst = 1'b1;
        #1;
        chk("to_rst_outs", 32'(outs), 32'(O_NONE));
        cyc();
        rst = 1'b0;
        idle();
        #1;
        chk("to_cleared", 32'(outs), 32'(O_NONE));
        chk("to_rst_sc", 32'(stall_cycles), 32'd0);
        chk("to_rst_sc4", 32'(stall_cycles4), 32'd0);

        mem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
        end
        rst = 1'b1;
        #1;
        chk("mw_rst_outs", 32'(outs), 32'(O_NONE));
        cyc();
        rst = 1'b0;
        #1;
        chk("mw_rst_run", 32'(outs), 32'(O_WAIT));
        chk("mw_rst_sc", 32'(stall_cycles), 32'd0);
        for (int i = 0; i < 15; i++) begin
            cyc();
        end
        chk("mw_rst_cnt16", 32'(outs), 32'(O_WAIT));
        cyc();
        chk("mw_rst_to", 32'(outs), 32'(O_TO));
        chk("mw_sc4_sat", 32'(stall_cycles4), 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: max consecutive data-memory wait cycles before timeout.
REQ-002 SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-003 SHALL have ports: clk input 1, sole clock, all state updates on posedge.
REQ-004 SHALL have ports: rst input 1, synchronous active-high reset.
REQ-005 SHALL have ports: id_inst input 16, instruction held in IF/ID; rs=[7:4], rt=[3:0].
REQ-006 SHALL have ports: id_uses_rt input 1, ID instruction reads rt.
REQ-007 SHALL have ports: idex_memread input 1 and idex_rd input 4, EX-stage load and its destination.
REQ-008 SHALL have ports: ex_branch_taken input 1, branch in EX resolved taken.
REQ-009 SHALL have ports: mem_req input 1 and mem_ready input 1, MEM-stage access and memory completion.
REQ-010 SHALL have outputs, 1 bit each: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall, memwb_bubble, mem_timeout.
REQ-011 SHALL have output stall_cycles, CNT_W bits: count of cycles with pc_stall high.

Function
REQ-012 SHALL drive all 1-bit outputs combinationally from current inputs and FSM state; no output X/Z after reset.
REQ-013 Load-use: SHALL flag hazard when idex_memread=1, idex_rd!=0, and idex_rd==rs, or id_uses_rt=1 and idex_rd==rt.
REQ-014 On load-use alone: pc_stall=1, ifid_stall=1, idex_bubble=1 for exactly that cycle.
REQ-015 Register 0 SHALL never cause a hazard.
REQ-016 On ex_branch_taken alone: ifid_flush=1, idex_bubble=1, pc_stall=0, for one cycle.
REQ-017 Memory wait (mem_req=1, mem_ready=0): pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_bubble all 1; ifid_flush=0, idex_bubble=0.
REQ-018 Priority: TIMEOUT > memory wait > branch flush > load-use.
REQ-019 Branch flush SHALL suppress load-use stall in the same cycle.
REQ-020 A branch or load-use coinciding with memory wait SHALL be deferred until the wait ends; inputs stay frozen while EX is frozen.
REQ-021 FSM states: RUN, MEM_WAIT, TIMEOUT.
REQ-022 RUN -> MEM_WAIT when mem_req=1 and mem_ready=0.
REQ-023 MEM_WAIT -> RUN when mem_ready=1 or mem_req=0.
REQ-024 MEM_WAIT -> TIMEOUT when wait_cnt==MAX_WAIT and mem_ready=0.
REQ-025 TIMEOUT SHALL be left only by rst.
REQ-026 wait_cnt (clog2(MAX_WAIT+1) bits) SHALL count consecutive wait cycles: cleared in RUN, incremented each MEM_WAIT cycle.
REQ-027 TIMEOUT SHALL hold mem_timeout=1 and all stall outputs of REQ-017 at 1.
REQ-028 mem_timeout SHALL be 0 in all other states.
REQ-029 stall_cycles SHALL increment on each clk where pc_stall=1 and SHALL saturate at all-ones, never wrapping.
REQ-030 mem_ready=1 with mem_req=0 SHALL be ignored.

Reset
REQ-031 rst=1 at posedge: state=RUN, wait_cnt=0, stall_cycles=0.
REQ-032 While rst=1, all 1-bit outputs SHALL be 0.
REQ-033 rst SHALL take precedence mid-wait and in TIMEOUT.
REQ-034 First post-reset cycle SHALL be in RUN.

Structure
REQ-035 Shared package cpu_pkg SHALL hold instruction field positions, REG_ZERO=4'd0, REG_W=4, INST_W=16 and the FSM state enum.
REQ-036 The combinational load-use compare SHALL be sub-module load_use_detect.
REQ-037 FSM, wait counter and stall counter SHALL stay in hazard_ctrl.

Verification
REQ-038 idex_memread=1, idex_rd=3, id_inst rs=3 -> one cycle pc_stall=ifid_stall=idex_bubble=1; stall_cycles=1.
REQ-039 idex_rd=0 with rs=0, and rt match with id_uses_rt=0 -> no stall.
REQ-040 ex_branch_taken=1 with concurrent load-use -> ifid_flush=1, idex_bubble=1, pc_stall=0.
REQ-041 mem_req=1, mem_ready low 3 cycles then high -> 3 cycles of full stall, RUN on 4th, stall_cycles=3, mem_timeout=0.
REQ-042 mem_ready low 17 cycles (MAX_WAIT=15) -> mem_timeout=1 from cycle 17 and held; rst clears it next posedge.
REQ-043 Force continuous stall with CNT_W=4 for 20 cycles -> stall_cycles sticks at 15; rst mid-MEM_WAIT -> RUN, counters 0.
